key_debounce_capture: RTL and testbench
=======================================

Name: key_debounce_capture

Overview:
- Sits directly downstream of the row/column decode stage, clocked on slow_clk.
- Consumes the decoded key_value / key_pressed pair plus the active one-hot column, and freezes the column scanner while a key is held.
- Debounces press and release, then emits exactly one single-cycle key_valid pulse with a stable key_code per physical press, for the display/accumulator logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical pressed samples needed to accept a key; legal range 2..255.
- RELEASE_CYCLES, 4: consecutive released samples needed to return to idle; legal range 2..255.
- CNT_W, 8: debounce counter width; must hold max(DEBOUNCE_CYCLES, RELEASE_CYCLES).

Ports:
- slow_clk  input  1  scan clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- col_shift_reg  input  4  one-hot active column from the column shifter.
- key_value  input  4  decoded key from the row/column decode stage.
- key_pressed  input  1  any row active, from the decode stage.
- scan_hold  output  1  high means the column shifter must not advance.
- key_code  output  4  last accepted key value; held until the next acceptance.
- key_valid  output  1  single-cycle pulse when a new key is accepted.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, cand_value=0, cand_col=0, key_code=0, key_valid=0. Reset overrides every other event, including mid-debounce and mid-press.
- FSM states, defined in keypad_pkg: IDLE, DEBOUNCE, PRESSED, RELEASE.
- "match" means key_pressed=1, key_value==cand_value and col_shift_reg==cand_col.
- IDLE:
  - If key_pressed=1: latch cand_value←key_value, cand_col←col_shift_reg, cnt←1, go to DEBOUNCE.
- DEBOUNCE:
  - On match with cnt==DEBOUNCE_CYCLES-1: go to PRESSED, key_code←cand_value, key_valid←1 for one cycle.
  - On match otherwise: cnt←cnt+1.
  - On mismatch or key_pressed=0: go to IDLE, cnt←0, no pulse.
- PRESSED:
  - key_pressed=0: go to RELEASE, cnt←1.
  - Otherwise stay. A value change while held is ignored; no new pulse.
- RELEASE:
  - key_pressed=1: go back to PRESSED, cnt←0. This is release bounce; no new pulse.
  - key_pressed=0 and cnt==RELEASE_CYCLES-1: go to IDLE.
  - Otherwise: cnt←cnt+1.
- Latency: key held from cycle 0 → key_valid high in cycle DEBOUNCE_CYCLES only; low in every other cycle.
- scan_hold:
  - Combinational: (state==IDLE && key_pressed) || state!=IDLE.
  - This stops the shifter in the same cycle the press is first seen.
- busy: registered decode of state!=IDLE.
- The counter never wraps; the comparisons above bound it.
- key_code stays stable through PRESSED/RELEASE/IDLE until the next accepted key.

Optional Feature:
- Macro KEY_REPEAT_EN; adds parameters REPEAT_DELAY (default 32) and REPEAT_PERIOD (default 8).
- Defined:
  - In PRESSED, a second counter runs.
  - First extra key_valid pulse after REPEAT_DELAY cycles in PRESSED, then one every REPEAT_PERIOD cycles, with the same key_code.
  - The counter clears on entry to PRESSED, on leaving PRESSED, and on reset.
  - Returning from RELEASE to PRESSED restarts REPEAT_DELAY.
- Undefined: exactly one pulse per press; no repeat logic synthesised.

Decomposition:
- keypad_pkg:
  - state enum key_state_t.
  - One-hot column constants COL1..COL4 (4'b1000..4'b0001).
  - KEY_W=4.
- One natural sub-module: debounce_counter, a clearable, enable-gated up-counter with a terminal-compare output. It is instantiated once for debounce/release, and a second time under KEY_REPEAT_EN.

Test Plan:
- Clean press: rst 2 cycles, then key_value=5, key_pressed=1, col=0010 held 10 cycles, DEBOUNCE_CYCLES=4 → key_valid=1 only in cycle 4, key_code=5, scan_hold=1 from cycle 0, busy=1 from cycle 1.
- Press bounce: key_pressed pattern 1,1,0,1,1,1,1 with value 8 → no pulse on the first burst; a single pulse 4 cycles after the second onset, key_code=8.
- Value glitch: key_value 2,2,3,3,3,3 with key_pressed steady → DEBOUNCE aborts at the change, restarts, and gives a single pulse with key_code=3.
- Release bounce: after acceptance, key_pressed 0,0,1,0,0,0,0 → back to PRESSED on the 1 with no second pulse; IDLE 4 cycles after the final release; busy falls; key_code still holds its value.
- Reset mid-operation: rst=1 during DEBOUNCE cnt=2, and again during PRESSED → next cycle state IDLE, key_valid=0, key_code=0, scan_hold follows key_pressed only.
- With KEY_REPEAT_EN, REPEAT_DELAY=32, REPEAT_PERIOD=8, key held 60 cycles → pulses at cycles 4, 36, 44, 52, 60; without the macro → only cycle 4.

Source files
------------

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared keypad types, state encodings and column constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

   localparam int KEY_W = 4;

   typedef logic [1:0] key_state_t;

   localparam key_state_t IDLE     = 2'd0;
   localparam key_state_t DEBOUNCE = 2'd1;
   localparam key_state_t PRESSED  = 2'd2;
   localparam key_state_t RELEASE  = 2'd3;

   localparam logic [3:0] COL1 = 4'b1000;
   localparam logic [3:0] COL2 = 4'b0100;
   localparam logic [3:0] COL3 = 4'b0010;
   localparam logic [3:0] COL4 = 4'b0001;

endpackage

`default_nettype wire

// File: rtl/key_debounce_capture_counter.sv
// ============================================================================
// Module      : debounce_counter
// Description : Clearable, enable-gated up-counter with terminal-compare flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module debounce_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_at_term
);

   logic [CNT_W-1:0] r_count;

   // Clear wins over load so a state exit can never leave a stale count behind.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (i_en) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_at_term = (r_count == i_term);

endmodule

`default_nettype wire

// File: rtl/key_debounce_capture.sv
// ============================================================================
// Module      : key_debounce_capture
// Description : Keypad press/release debouncer emitting one key_valid pulse
//               per press; optional auto-repeat under KEY_REPEAT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_debounce_capture
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RELEASE_CYCLES  = 4,
   parameter int CNT_W           = 8
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
`endif
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic [3:0]       col_shift_reg,
   input  logic [KEY_W-1:0] key_value,
   input  logic             key_pressed,
   output logic             scan_hold,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_db_term  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_rel_term = CNT_W'(RELEASE_CYCLES - 1);

   key_state_t       r_state;
   key_state_t       w_state_nxt;
   logic [KEY_W-1:0] r_cand_value;
   logic [3:0]       r_cand_col;
   logic [KEY_W-1:0] r_key_code;
   logic             r_key_valid;
   logic             r_busy;

   logic             w_match;
   logic             w_accept;
   logic             w_rpt_pulse;
   logic             w_cnt_clr;
   logic             w_cnt_load;
   logic             w_cnt_en;
   logic             w_cnt_at_term;
   logic [CNT_W-1:0] w_cnt_term;

   assign w_match    = key_pressed && (key_value == r_cand_value) && (col_shift_reg == r_cand_col);
   assign w_cnt_term = (r_state == RELEASE) ? c_rel_term : c_db_term;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_en    = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_pressed) begin
               w_state_nxt = DEBOUNCE;
               w_cnt_load  = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (w_match && w_cnt_at_term) begin
               w_state_nxt = PRESSED;
               w_cnt_clr   = 1'b1;
               w_accept    = 1'b1;
            end else if (w_match) begin
               w_cnt_en    = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_clr   = 1'b1;
            end
         end
         PRESSED: begin
            if (!key_pressed) begin
               w_state_nxt = RELEASE;
               w_cnt_load  = 1'b1;
            end
         end
         RELEASE: begin
            if (key_pressed) begin
               w_state_nxt = PRESSED;
               w_cnt_clr   = 1'b1;
            end else if (w_cnt_at_term) begin
               w_state_nxt = IDLE;
               w_cnt_clr   = 1'b1;
            end else begin
               w_cnt_en    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   debounce_counter #(
      .CNT_W     (CNT_W)
   ) u_db_cnt (
      .clk       (slow_clk),
      .rst       (rst),
      .i_clr     (w_cnt_clr),
      .i_load    (w_cnt_load),
      .i_en      (w_cnt_en),
      .i_term    (w_cnt_term),
      .o_at_term (w_cnt_at_term)
   );

`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] c_rpt_delay_term  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_rpt_period_term = CNT_W'(REPEAT_PERIOD - 1);

   logic r_rpt_armed;
   logic w_rpt_at_term;
   logic w_rpt_clr;

   // Counter is held at zero outside PRESSED, so every entry restarts the delay.
   assign w_rpt_pulse = (r_state == PRESSED) && key_pressed && w_rpt_at_term;
   assign w_rpt_clr   = (r_state != PRESSED) || w_rpt_pulse;

   always_ff @(posedge slow_clk) begin
      if (rst || (r_state != PRESSED)) begin
         r_rpt_armed <= 1'b0;
      end else if (w_rpt_pulse) begin
         r_rpt_armed <= 1'b1;
      end
   end

   debounce_counter #(
      .CNT_W     (CNT_W)
   ) u_rpt_cnt (
      .clk       (slow_clk),
      .rst       (rst),
      .i_clr     (w_rpt_clr),
      .i_load    (1'b0),
      .i_en      (r_state == PRESSED),
      .i_term    (r_rpt_armed ? c_rpt_period_term : c_rpt_delay_term),
      .o_at_term (w_rpt_at_term)
   );
`else
   assign w_rpt_pulse = 1'b0;
`endif

   always_ff @(posedge slow_clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cand_value <= '0;
         r_cand_col   <= '0;
         r_key_code   <= '0;
         r_key_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_key_valid <= w_accept || w_rpt_pulse;
         r_busy      <= (w_state_nxt != IDLE);
         if ((r_state == IDLE) && key_pressed) begin
            r_cand_value <= key_value;
            r_cand_col   <= col_shift_reg;
         end
         if (w_accept) begin
            r_key_code <= r_cand_value;
         end
      end
   end

   assign scan_hold = key_pressed || (r_state != IDLE);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_capture.sv
// ============================================================================
// Module      : tb_key_debounce_capture
// Description : Scoreboard bench for key_debounce_capture (honours KEY_REPEAT_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_debounce_capture;
   import keypad_pkg::*;

   logic       slow_clk = 1'b0;
   logic       rst;
   logic [3:0] col_shift_reg;
   logic [3:0] key_value;
   logic       key_pressed;
   logic       scan_hold;
   logic [3:0] key_code;
   logic       key_valid;
   logic       busy;

   int cyc       = 0;
   int n_checks  = 0;
   int n_errors  = 0;

   typedef struct {
      int         at;
      logic [3:0] code;
   } exp_t;

   exp_t exp_q[$];

   key_debounce_capture #(
      .DEBOUNCE_CYCLES (4),
      .RELEASE_CYCLES  (4),
      .CNT_W           (8)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY    (32),
      .REPEAT_PERIOD   (8)
`endif
   ) u_dut (
      .slow_clk      (slow_clk),
      .rst           (rst),
      .col_shift_reg (col_shift_reg),
      .key_value     (key_value),
      .key_pressed   (key_pressed),
      .scan_hold     (scan_hold),
      .key_code      (key_code),
      .key_valid     (key_valid),
      .busy          (busy)
   );

   always #5 slow_clk = ~slow_clk;

   always @(posedge slow_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every observed pulse must match the oldest outstanding expectation.
   always @(negedge slow_clk) begin
      exp_t e;
      if (key_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_pulse", {31'b0, key_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", cyc, e.at);
            chk("pulse_code", {28'b0, key_code}, {28'b0, e.code});
         end
      end
   end

   task automatic tick();
      @(posedge slow_clk);
      #1;
   endtask

   task automatic drive(input logic kp, input logic [3:0] val, input logic [3:0] col);
      key_pressed   = kp;
      key_value     = val;
      col_shift_reg = col;
      #1;
   endtask

   task automatic push(input int at, input logic [3:0] code);
      exp_t e;
      e.at   = at;
      e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic release_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 4'h0, COL4);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int pb_kp[9]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
      int vg_val[9] = '{2, 2, 3, 3, 3, 3, 3, 3, 3};
      int rb_kp[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};

      rst           = 1'b1;
      key_pressed   = 1'b0;
      key_value     = 4'h0;
      col_shift_reg = COL4;
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 4'h0, COL4);
      chk("rst_valid", {31'b0, key_valid}, 32'd0);
      chk("rst_code", {28'b0, key_code}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hold", {31'b0, scan_hold}, 32'd0);
      tick();

      // Clean press
      base = cyc;
      push(base + 4, 4'h5);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 4'h5, COL3);
         if (k == 0) begin
            chk("clean_hold_c0", {31'b0, scan_hold}, 32'd1);
            chk("clean_busy_c0", {31'b0, busy}, 32'd0);
         end
         if (k == 1) chk("clean_busy_c1", {31'b0, busy}, 32'd1);
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 4'h5, COL3);
         if (k == 3) chk("clean_busy_r3", {31'b0, busy}, 32'd1);
         if (k == 4) begin
            chk("clean_busy_r4", {31'b0, busy}, 32'd0);
            chk("clean_hold_r4", {31'b0, scan_hold}, 32'd0);
            chk("clean_code_r4", {28'b0, key_code}, 32'h5);
         end
         tick();
      end
      chk("clean_pending", exp_q.size(), 32'd0);

      // Press bounce
      base = cyc;
      push(base + 7, 4'h8);
      for (int k = 0; k < 9; k++) begin
         drive(pb_kp[k][0], 4'h8, COL2);
         tick();
      end
      release_n(6);
      chk("bounce_pending", exp_q.size(), 32'd0);
      chk("bounce_code", {28'b0, key_code}, 32'h8);

      // Value glitch
      base = cyc;
      push(base + 7, 4'h3);
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, vg_val[k][3:0], COL1);
         if (k == 2) chk("glitch_hold_c2", {31'b0, scan_hold}, 32'd1);
         if (k == 3) chk("glitch_busy_c3", {31'b0, busy}, 32'd0);
         tick();
      end
      release_n(6);
      chk("glitch_pending", exp_q.size(), 32'd0);

      // Release bounce
      base = cyc;
      push(base + 4, 4'hA);
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 4'hA, COL4);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         drive(rb_kp[k][0], 4'hA, COL4);
         if (k == 2) chk("relb_busy_r2", {31'b0, busy}, 32'd1);
         if (k == 6) chk("relb_busy_r6", {31'b0, busy}, 32'd1);
         if (k == 7) begin
            chk("relb_busy_r7", {31'b0, busy}, 32'd0);
            chk("relb_code_r7", {28'b0, key_code}, 32'hA);
         end
         tick();
      end
      chk("relb_pending", exp_q.size(), 32'd0);

      // Reset during DEBOUNCE (cnt=2)
      for (int k = 0; k < 3; k++) begin
         if (k == 2) rst = 1'b1;
         drive(1'b1, 4'h6, COL1);
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 4'h6, COL1);
      chk("rstdb_valid", {31'b0, key_valid}, 32'd0);
      chk("rstdb_code", {28'b0, key_code}, 32'd0);
      chk("rstdb_busy", {31'b0, busy}, 32'd0);
      chk("rstdb_hold", {31'b0, scan_hold}, 32'd0);
      tick();

      // Reset during PRESSED
      base = cyc;
      push(base + 4, 4'h7);
      for (int k = 0; k < 8; k++) begin
         if (k == 7) rst = 1'b1;
         drive(1'b1, 4'h7, COL2);
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 4'h7, COL2);
      chk("rstpr_valid", {31'b0, key_valid}, 32'd0);
      chk("rstpr_code", {28'b0, key_code}, 32'd0);
      chk("rstpr_busy", {31'b0, busy}, 32'd0);
      chk("rstpr_hold", {31'b0, scan_hold}, 32'd0);
      tick();
      drive(1'b1, 4'h7, COL2);
      chk("rstpr_hold_kp", {31'b0, scan_hold}, 32'd1);
      tick();
      release_n(6);
      chk("rst_pending", exp_q.size(), 32'd0);

      // Long hold: repeat pulses only when the feature is built in
      base = cyc;
      push(base + 4, 4'h9);
`ifdef KEY_REPEAT_EN
      push(base + 36, 4'h9);
      push(base + 44, 4'h9);
      push(base + 52, 4'h9);
      push(base + 60, 4'h9);
`endif
      for (int k = 0; k < 62; k++) begin
         drive(1'b1, 4'h9, COL2);
         if (k == 50) chk("hold_code_c50", {28'b0, key_code}, 32'h9);
         tick();
      end
      release_n(6);
      chk("hold_pending", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
